// File: rtl/accumulator_pkg.sv
// accumulator_pkg
// Shared types and default constants for the phase-accumulator family.
// The meter FSM state type lives here so that the top level and any
// future monitors agree on the encoding.
//
// Contents:
//   meter_state_t - frequency-meter FSM states {IDLE, ARM, GATE, DONE}
//   DEF_*         - default widths used as parameter defaults
//   GATE_CYCLES   - gate window length for the default GATE_LOG2
//   SHIFT         - count-to-increment scaling shift for the defaults
package accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2,
    DONE = 2'd3
  } meter_state_t;

  localparam int DEF_ACC_WIDTH = 8;
  localparam int DEF_ADD_WIDTH = 8;
  localparam int DEF_GATE_LOG2 = 12;

  localparam int GATE_CYCLES = 2 ** DEF_GATE_LOG2;
  localparam int SHIFT       = DEF_GATE_LOG2 - DEF_ACC_WIDTH;

endpackage

// File: rtl/accumulator_freq_meter_edge_sync.sv
// edge_sync
// Brings an asynchronous square wave into the clk domain and flags its
// rising edges. s1/s2 form the metastability synchroniser; s3 holds the
// previous synchronised value so that rise = s2 & ~s3. The pin-to-rise
// latency is a constant two clocks, so it does not bias a gated count.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   sig_in - asynchronous input stream
//   rise   - one-clock pulse per synchronised rising edge
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise
);

  logic s1_r;
  logic s2_r;
  logic s3_r;

  // Synchroniser chain plus history flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= sig_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign rise = s2_r & ~s3_r;

endmodule

// File: rtl/accumulator_freq_meter.sv
// accumulator_freq_meter
// Recovers the increment of a phase accumulator from its MSB seen on a
// pin. After a start, the meter waits for a rising edge (arming edge,
// not counted), then counts rising edges over 2^GATE_LOG2 clocks and
// scales the count down to an increment estimate.
//
// Ports:
//   clk, rst    - clock and synchronous active-high reset
//   start       - begin a measurement (only looked at in IDLE)
//   continuous  - re-arm after each result (only looked at in DONE)
//   sig_in      - asynchronous MSB stream
//   busy        - high whenever the meter is not idle
//   valid       - one-clock pulse when the result outputs update
//   estimate    - recovered increment, saturating
//   edge_count  - raw rising-edge count of the last window
//   timeout     - last measurement never saw an arming edge
module accumulator_freq_meter
  import accumulator_pkg::*;
#(
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int ADD_WIDTH = DEF_ADD_WIDTH,
  parameter int GATE_LOG2 = DEF_GATE_LOG2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 continuous,
  input  logic                 sig_in,
  output logic                 busy,
  output logic                 valid,
  output logic [ADD_WIDTH-1:0] estimate,
  output logic [GATE_LOG2:0]   edge_count,
  output logic                 timeout
);

  localparam int CNT_W    = GATE_LOG2 + 1;
  localparam int LP_SHIFT = GATE_LOG2 - ACC_WIDTH;
  // Value the gate counter holds on the last clock of a window.
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'((2 ** GATE_LOG2) - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  if (ADD_WIDTH > ACC_WIDTH) begin : g_bad_add_width
    $error("accumulator_freq_meter: ADD_WIDTH must not exceed ACC_WIDTH");
  end
  if (GATE_LOG2 < ACC_WIDTH) begin : g_bad_gate_log2
    $error("accumulator_freq_meter: GATE_LOG2 must be at least ACC_WIDTH");
  end

  logic                 rise_s;
  meter_state_t         state_r;
  meter_state_t         state_next_s;
  logic [CNT_W-1:0]     gate_cnt_r;
  logic [CNT_W-1:0]     gate_cnt_next_s;
  logic [CNT_W-1:0]     edge_cnt_r;
  logic [CNT_W-1:0]     edge_cnt_next_s;
  logic                 tmo_r;
  logic                 tmo_next_s;
  logic [CNT_W-1:0]     shifted_s;
  logic [ADD_WIDTH-1:0] est_s;

  logic                 busy_r;
  logic                 valid_r;
  logic [ADD_WIDTH-1:0] estimate_r;
  logic [CNT_W-1:0]     edge_count_r;
  logic                 timeout_r;

  edge_sync u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .rise   (rise_s)
  );

  // Next-state, gate counter and edge counter logic.
  always_comb begin
    state_next_s    = state_r;
    gate_cnt_next_s = gate_cnt_r;
    edge_cnt_next_s = edge_cnt_r;
    tmo_next_s      = tmo_r;
    case (state_r)
      IDLE: begin
        gate_cnt_next_s = '0;
        edge_cnt_next_s = '0;
        tmo_next_s      = 1'b0;
        if (start) begin
          state_next_s = ARM;
        end else begin
          state_next_s = IDLE;
        end
      end
      ARM: begin
        // A rise on the final waiting clock still arms the window.
        if (rise_s) begin
          state_next_s    = GATE;
          gate_cnt_next_s = '0;
        end else if (gate_cnt_r == LAST_TICK) begin
          state_next_s    = DONE;
          gate_cnt_next_s = '0;
          tmo_next_s      = 1'b1;
        end else begin
          gate_cnt_next_s = gate_cnt_r + CNT_ONE;
        end
      end
      GATE: begin
        gate_cnt_next_s = gate_cnt_r + CNT_ONE;
        // The clock that closes the window still counts its rise.
        if (rise_s) begin
          edge_cnt_next_s = edge_cnt_r + CNT_ONE;
        end else begin
          edge_cnt_next_s = edge_cnt_r;
        end
        if (gate_cnt_r == LAST_TICK) begin
          state_next_s = DONE;
        end else begin
          state_next_s = GATE;
        end
      end
      DONE: begin
        gate_cnt_next_s = '0;
        edge_cnt_next_s = '0;
        tmo_next_s      = 1'b0;
        if (continuous) begin
          state_next_s = ARM;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s    = IDLE;
        gate_cnt_next_s = '0;
        edge_cnt_next_s = '0;
        tmo_next_s      = 1'b0;
      end
    endcase
  end

  // FSM state and measurement counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      gate_cnt_r <= '0;
      edge_cnt_r <= '0;
      tmo_r      <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      gate_cnt_r <= gate_cnt_next_s;
      edge_cnt_r <= edge_cnt_next_s;
      tmo_r      <= tmo_next_s;
    end
  end

  // Scale the count to an increment and saturate at the output width.
  always_comb begin
    shifted_s = edge_cnt_r >> LP_SHIFT;
    if ((shifted_s >> ADD_WIDTH) != {CNT_W{1'b0}}) begin
      est_s = {ADD_WIDTH{1'b1}};
    end else begin
      est_s = shifted_s[ADD_WIDTH-1:0];
    end
  end

  // Result and status output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r       <= 1'b0;
      valid_r      <= 1'b0;
      estimate_r   <= '0;
      edge_count_r <= '0;
      timeout_r    <= 1'b0;
    end else begin
      // Busy follows the state being entered so start is never re-taken.
      busy_r  <= (state_next_s != IDLE);
      valid_r <= (state_r == DONE);
      if (state_r == DONE) begin
        estimate_r   <= est_s;
        edge_count_r <= edge_cnt_r;
        timeout_r    <= tmo_r;
      end else begin
        estimate_r   <= estimate_r;
        edge_count_r <= edge_count_r;
        timeout_r    <= timeout_r;
      end
    end
  end

  assign busy       = busy_r;
  assign valid      = valid_r;
  assign estimate   = estimate_r;
  assign edge_count = edge_count_r;
  assign timeout    = timeout_r;

endmodule

// File: tb/tb_accumulator_freq_meter.sv
// Bench for accumulator_freq_meter: a reference accumulator drives sig_in
// from the same clock; expected results are queued when a measurement is
// started and a separate monitor compares them when valid pulses.
module tb_accumulator_freq_meter;

  localparam int GATE_N = 4096;
  localparam int SAMP_N = 131072;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        continuous;
  logic        sig_in;
  logic        busy;
  logic        valid;
  logic [7:0]  estimate;
  logic [12:0] edge_count;
  logic        timeout;

  typedef struct {
    int cnt_lo;
    int cnt_hi;
    int est_lo;
    int est_hi;
    bit tmo;
    int vedge;
    bit chk_arm;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         n_vec = 0;
  int         n_miss = 0;
  int         cyc = 0;
  bit         samp [0:SAMP_N-1];
  logic [7:0] acc = 8'd0;
  logic [7:0] add_value = 8'd0;
  bit         acc_clear = 1'b0;
  bit         prev_valid = 1'b0;
  bit         cont_watch = 1'b0;
  int         last_vedge = -1;
  int         busy_drops = 0;
  int         k_edge;

  always #5 clk = ~clk;

  accumulator_freq_meter dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .continuous (continuous),
    .sig_in     (sig_in),
    .busy       (busy),
    .valid      (valid),
    .estimate   (estimate),
    .edge_count (edge_count),
    .timeout    (timeout)
  );

  task automatic chk(input string name, input bit ok, input int act, input int req);
    n_vec++;
    if (!ok) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input int clo, input int chi, input int elo, input int ehi,
                          input bit tmo, input int vedge, input bit arm);
    exp_t e;
    e.cnt_lo = clo; e.cnt_hi = chi; e.est_lo = elo; e.est_hi = ehi;
    e.tmo = tmo; e.vedge = vedge; e.chk_arm = arm;
    sb_q.push_back(e);
  endtask

  task automatic wait_results(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("result_wait_expired", 1'b0, sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  // One non-continuous measurement with a whole-number expected count.
  task automatic measure(input logic [7:0] addv);
    @(negedge clk);
    add_value = addv;
    repeat (300) @(negedge clk);
    start = 1'b1;
    push_exp(16 * int'(addv), 16 * int'(addv), int'(addv), int'(addv), 1'b0, -1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    wait_results(4700);
    chk("busy_after_result", busy == 1'b0, busy, 0);
  endtask

  // Record sig_in as the DUT synchroniser samples it at each edge.
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    samp[cyc % SAMP_N] = sig_in;
  end

  // Reference phase accumulator; sig_in is its MSB.
  initial begin
    sig_in = 1'b0;
    forever begin
      @(negedge clk);
      if (acc_clear) begin
        acc = 8'd0;
        acc_clear = 1'b0;
      end else begin
        acc = acc + add_value;
      end
      sig_in = acc[7];
    end
  end

  // Monitor: compare each valid pulse with the oldest expected result.
  initial forever begin
    @(negedge clk);
    if (cont_watch && !busy) busy_drops++;
    if (valid) begin
      chk("valid_one_cycle", !prev_valid, int'(prev_valid), 0);
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", 1'b0, int'(edge_count), -1);
      end else begin
        mon_e = sb_q.pop_front();
        chk("edge_count", int'(edge_count) >= mon_e.cnt_lo && int'(edge_count) <= mon_e.cnt_hi,
            int'(edge_count), mon_e.cnt_lo);
        chk("estimate", int'(estimate) >= mon_e.est_lo && int'(estimate) <= mon_e.est_hi,
            int'(estimate), mon_e.est_lo);
        chk("timeout", timeout == mon_e.tmo, int'(timeout), int'(mon_e.tmo));
        if (mon_e.vedge >= 0) chk("timeout_latency", cyc == mon_e.vedge, cyc, mon_e.vedge);
        // Arming edge sits GATE_N+1 clocks before valid; its rise pulse
        // reflects a 0->1 step in sig_in sampled two and three edges earlier.
        if (mon_e.chk_arm)
          chk("arm_latency", samp[(cyc - GATE_N - 3) % SAMP_N] == 1'b1 &&
                             samp[(cyc - GATE_N - 4) % SAMP_N] == 1'b0, cyc, cyc);
        if (cont_watch && last_vedge >= 0)
          chk("continuous_spacing", (cyc - last_vedge) >= GATE_N + 2 &&
                                    (cyc - last_vedge) <= GATE_N + 20,
              cyc - last_vedge, GATE_N + 2);
        last_vedge = cyc;
      end
    end
    prev_valid = valid;
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    continuous = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy == 1'b0, busy, 0);
    chk("reset_valid", valid == 1'b0, valid, 0);
    chk("reset_estimate", estimate == 8'd0, estimate, 0);
    chk("reset_edge_count", edge_count == 13'd0, edge_count, 0);
    chk("reset_timeout", timeout == 1'b0, timeout, 0);
    rst = 1'b0;

    // add_value 16: exact 256 edges, estimate 16, busy on the start edge.
    add_value = 8'd16;
    repeat (50) @(negedge clk);
    chk("busy_before_start", busy == 1'b0, busy, 0);
    start = 1'b1;
    push_exp(256, 256, 16, 16, 1'b0, -1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    chk("busy_on_start", busy == 1'b1, busy, 1);
    wait_results(4700);
    chk("busy_after_result", busy == 1'b0, busy, 0);

    measure(8'd1);
    measure(8'd3);
    measure(8'd100);
    measure(8'd128);

    // No edges at all: timeout result GATE_N+1 clocks after ARM is entered.
    @(negedge clk);
    add_value = 8'd0;
    acc_clear = 1'b1;
    repeat (10) @(negedge clk);
    start = 1'b1;
    k_edge = cyc + 1;
    push_exp(0, 0, 0, 0, 1'b1, k_edge + GATE_N + 1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_results(4700);

    // Continuous mode with a frequency change in the second window.
    @(negedge clk);
    add_value = 8'd16;
    repeat (300) @(negedge clk);
    last_vedge = -1;
    cont_watch = 1'b1;
    continuous = 1'b1;
    start = 1'b1;
    push_exp(256, 256, 16, 16, 1'b0, -1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    wait_results(4700);
    repeat (100) @(negedge clk);
    add_value = 8'd32;
    push_exp(256, 512, 16, 32, 1'b0, -1, 1'b1);
    push_exp(512, 512, 32, 32, 1'b0, -1, 1'b1);
    wait_results(9000);
    repeat (100) @(negedge clk);
    continuous = 1'b0;
    cont_watch = 1'b0;
    push_exp(512, 512, 32, 32, 1'b0, -1, 1'b1);
    wait_results(4700);
    repeat (2) @(negedge clk);
    chk("idle_after_continuous", busy == 1'b0, busy, 0);
    chk("busy_never_dropped", busy_drops == 0, busy_drops, 0);

    // Reset 1000 clocks into a window: abort, no result, then re-measure.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (1000) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy == 1'b0, busy, 0);
    chk("abort_estimate", estimate == 8'd0, estimate, 0);
    chk("abort_edge_count", edge_count == 13'd0, edge_count, 0);
    chk("abort_valid", valid == 1'b0, valid, 0);
    repeat (4300) @(negedge clk);
    measure(8'd16);

    // A second start during the window is ignored.
    start = 1'b1;
    push_exp(256, 256, 16, 16, 1'b0, -1, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (500) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_results(4700);
    repeat (4300) @(negedge clk);
    chk("idle_after_ignored_start", busy == 1'b0, busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
